// File: rtl/tbird_signal_ctrl.sv
// Request sequencer ahead of the tail-light FSM: synchronises switch
// inputs, arbitrates turn/hazard modes and paces light steps.
module tbird_signal_ctrl #(
    parameter int DIV     = 4,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left_in,
    input  logic       right_in,
    input  logic       haz_in,
    input  logic       cancel_in,
    output logic       fsm_left,
    output logic       fsm_right,
    output logic       fsm_haz,
    output logic       fsm_en,
    output logic [1:0] mode,
    output logic [1:0] phase,
    output logic       pend_valid
);

    localparam int CW = $clog2(DIV);
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [SW-1:0] SEQ_MAX = SW'(TIMEOUT);

    typedef enum logic [1:0] {
        M_IDLE  = 2'b00,
        M_LEFT  = 2'b01,
        M_RIGHT = 2'b10,
        M_HAZ   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        P_NONE,
        P_LEFT,
        P_RIGHT,
        P_CANCEL
    } pend_t;

    logic [3:0] raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] prev_q;
    logic [3:0] edge_q;
    logic [1:0] warm_q;

    assign raw = {cancel_in, haz_in, right_in, left_in};

    // prev_q starts high and only tracks the synchroniser once it holds
    // real samples, so a level held through reset never looks like a rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '1;
            edge_q  <= '0;
            warm_q  <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            warm_q  <= {warm_q[0], 1'b1};
            if (warm_q[1])
                prev_q <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    logic both_e;
    logic haz_e;
    logic left_e;
    logic right_e;
    logic can_e;

    assign both_e  = edge_q[0] & edge_q[1];
    assign haz_e   = edge_q[2] | both_e;
    assign left_e  = edge_q[0] & ~edge_q[1];
    assign right_e = edge_q[1] & ~edge_q[0];
    assign can_e   = edge_q[3];

    mode_t         mode_q, mode_d;
    pend_t         pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [SW-1:0] seq_q, seq_d;
    logic [SW-1:0] seq_inc;
    logic          restart;
    logic          tick;
    logic          boundary;
    logic          same_dir;

    assign tick     = (mode_q != M_IDLE) && (cnt_q == CNT_MAX);
    assign boundary = tick && (phase_q == 2'd3);
    assign same_dir = (left_e && (mode_q == M_LEFT))
                   || (right_e && (mode_q == M_RIGHT));

    always_comb begin
        mode_d  = mode_q;
        pend_d  = pend_q;
        seq_d   = seq_q;
        seq_inc = seq_q;
        restart = 1'b0;
        unique case (mode_q)
            M_IDLE: begin
                seq_d  = '0;
                pend_d = P_NONE;
                if (haz_e) begin
                    mode_d  = M_HAZ;
                    restart = 1'b1;
                end else if (left_e) begin
                    mode_d  = M_LEFT;
                    restart = 1'b1;
                end else if (right_e) begin
                    mode_d  = M_RIGHT;
                    restart = 1'b1;
                end
            end
            M_LEFT, M_RIGHT: begin
                if (haz_e) begin
                    mode_d  = M_HAZ;
                    pend_d  = P_NONE;
                    seq_d   = '0;
                    restart = 1'b1;
                end else begin
                    if (left_e || right_e) begin
                        if (same_dir)
                            seq_d = '0;
                        else
                            pend_d = left_e ? P_LEFT : P_RIGHT;
                    end else if (can_e) begin
                        pend_d = P_CANCEL;
                    end
                    if (boundary) begin
                        unique case (pend_d)
                            P_LEFT: begin
                                mode_d = M_LEFT;
                                seq_d  = '0;
                                pend_d = P_NONE;
                            end
                            P_RIGHT: begin
                                mode_d = M_RIGHT;
                                seq_d  = '0;
                                pend_d = P_NONE;
                            end
                            P_CANCEL: begin
                                mode_d = M_IDLE;
                                pend_d = P_NONE;
                            end
                            P_NONE: begin
                                seq_inc = (seq_d == SEQ_MAX)
                                        ? seq_d : seq_d + SW'(1);
                                seq_d   = seq_inc;
                                if (seq_inc == SEQ_MAX)
                                    mode_d = M_IDLE;
                            end
                        endcase
                    end
                end
            end
            M_HAZ: begin
                if (haz_e) begin
                    mode_d  = M_IDLE;
                    restart = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        if (restart || (mode_d == M_IDLE)) begin
            cnt_d   = '0;
            phase_d = 2'd0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= M_IDLE;
            pend_q  <= P_NONE;
            cnt_q   <= '0;
            phase_q <= 2'd0;
            seq_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            seq_q   <= seq_d;
        end
    end

    assign mode       = mode_q;
    assign phase      = phase_q;
    assign pend_valid = (pend_q != P_NONE);
    assign fsm_en     = tick;
    assign fsm_left   = (mode_q == M_LEFT);
    assign fsm_right  = (mode_q == M_RIGHT);
    assign fsm_haz    = (mode_q == M_HAZ);

endmodule

// File: tb/tb_tbird_signal_ctrl.sv
// Scoreboard bench for tbird_signal_ctrl: directed pulses queue the
// expected mode/step events, a monitor checks them as they appear.
module tb_tbird_signal_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left_in = 1'b0;
    logic       right_in = 1'b0;
    logic       haz_in = 1'b0;
    logic       cancel_in = 1'b0;
    logic       fsm_left;
    logic       fsm_right;
    logic       fsm_haz;
    logic       fsm_en;
    logic [1:0] mode;
    logic [1:0] phase;
    logic       pend_valid;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int         c;
        logic [1:0] m;
        logic [1:0] p;
        logic       pv;
        logic       en;
    } ev_t;

    ev_t q[$];

    tbird_signal_ctrl #(.DIV(4), .TIMEOUT(3)) dut (
        .clk(clk),
        .rst(rst),
        .left_in(left_in),
        .right_in(right_in),
        .haz_in(haz_in),
        .cancel_in(cancel_in),
        .fsm_left(fsm_left),
        .fsm_right(fsm_right),
        .fsm_haz(fsm_haz),
        .fsm_en(fsm_en),
        .mode(mode),
        .phase(phase),
        .pend_valid(pend_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: an event is a step pulse or any change in mode/pend_valid
    logic [1:0] prev_m = 2'b00;
    logic       prev_pv = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_m  = mode;
            prev_pv = pend_valid;
        end else begin
            if (fsm_en || (mode != prev_m) || (pend_valid != prev_pv)) begin
                ev_t e;
                logic ok;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event cyc=%0d got m=%b p=%0d pv=%b en=%b want none",
                             cyc, mode, phase, pend_valid, fsm_en);
                end else begin
                    e  = q.pop_front();
                    ok = (cyc == e.c) && (mode === e.m) && (phase === e.p)
                      && (pend_valid === e.pv) && (fsm_en === e.en)
                      && (fsm_left === (e.m == 2'b01))
                      && (fsm_right === (e.m == 2'b10))
                      && (fsm_haz === (e.m == 2'b11));
                    if (!ok) begin
                        bad++;
                        $display("FAIL event got c=%0d m=%b p=%0d pv=%b en=%b lrh=%b%b%b want c=%0d m=%b p=%0d pv=%b en=%b",
                                 cyc, mode, phase, pend_valid, fsm_en,
                                 fsm_left, fsm_right, fsm_haz,
                                 e.c, e.m, e.p, e.pv, e.en);
                    end
                end
            end
            prev_m  = mode;
            prev_pv = pend_valid;
        end
    end

    task automatic push(input int c, input logic [1:0] m,
                        input logic [1:0] p, input logic pv,
                        input logic en);
        ev_t e;
        e.c  = c;
        e.m  = m;
        e.p  = p;
        e.pv = pv;
        e.en = en;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic at_neg(input int c);
        if (cyc > c) begin
            total++;
            bad++;
            $display("FAIL sched got cyc=%0d want <=%0d", cyc, c);
        end
        while (cyc < c) @(negedge clk);
    endtask

    // v = {cancel, haz, right, left}; sampled by the clock edge numbered c
    task automatic pulse(input int c, input logic [3:0] v);
        at_neg(c - 1);
        {cancel_in, haz_in, right_in, left_in} = v;
        @(negedge clk);
        {cancel_in, haz_in, right_in, left_in} = 4'b0000;
    endtask

    task automatic drain(input int c, input string nm);
        at_neg(c);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s got pending=%0d want 0", nm, q.size());
            q.delete();
        end
    endtask

    int n;
    int b;

    initial begin
        #1;
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_outs", 32'({fsm_left, fsm_right, fsm_haz, fsm_en}), 32'd0);
        chk("rst_phase_pend", 32'({phase, pend_valid}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-LEFT with left held through release
        n = cyc + 2;
        b = n + 3;
        push(b, 2'd1, 2'd0, 1'b0, 1'b0);
        push(b + 3, 2'd1, 2'd0, 1'b0, 1'b1);
        pulse(n, 4'b0001);
        at_neg(b + 5);
        #2;
        rst = 1'b1;
        left_in = 1'b1;
        #1;
        chk("async_rst_mode", 32'(mode), 32'd0);
        chk("async_rst_outs", 32'({fsm_left, fsm_right, fsm_haz, fsm_en}), 32'd0);
        chk("async_rst_phase_pend", 32'({phase, pend_valid}), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        left_in = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_level_mode", 32'(mode), 32'd0);
        drain(cyc, "rst_drain");

        // Left pulse runs three sequences then times out
        n = cyc + 2;
        b = n + 3;
        push(b, 2'd1, 2'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++)
            push(b + 4 * i - 1, 2'd1, 2'((i - 1) % 4), 1'b0, 1'b1);
        push(b + 48, 2'd0, 2'd0, 1'b0, 1'b0);
        pulse(n, 4'b0001);
        drain(b + 54, "timeout_drain");

        // Deferred switch to RIGHT, hazard preempt, hazard toggle off
        n = cyc + 2;
        b = n + 3;
        push(b, 2'd1, 2'd0, 1'b0, 1'b0);
        push(b + 3, 2'd1, 2'd0, 1'b0, 1'b1);
        push(b + 5, 2'd1, 2'd1, 1'b1, 1'b0);
        push(b + 7, 2'd1, 2'd1, 1'b1, 1'b1);
        push(b + 11, 2'd1, 2'd2, 1'b1, 1'b1);
        push(b + 15, 2'd1, 2'd3, 1'b1, 1'b1);
        push(b + 16, 2'd2, 2'd0, 1'b0, 1'b0);
        push(b + 19, 2'd2, 2'd0, 1'b0, 1'b1);
        push(b + 23, 2'd2, 2'd1, 1'b0, 1'b1);
        push(b + 25, 2'd3, 2'd0, 1'b0, 1'b0);
        push(b + 28, 2'd3, 2'd0, 1'b0, 1'b1);
        push(b + 30, 2'd0, 2'd0, 1'b0, 1'b0);
        pulse(n, 4'b0001);
        pulse(b + 2, 4'b0010);
        pulse(b + 22, 4'b0100);
        pulse(b + 27, 4'b0100);
        drain(b + 36, "switch_haz_drain");

        // Left+right together act as hazard; cancel ignored in HAZ
        n = cyc + 2;
        b = n + 3;
        push(b, 2'd3, 2'd0, 1'b0, 1'b0);
        push(b + 3, 2'd3, 2'd0, 1'b0, 1'b1);
        push(b + 7, 2'd3, 2'd1, 1'b0, 1'b1);
        push(b + 9, 2'd0, 2'd0, 1'b0, 1'b0);
        pulse(n, 4'b0011);
        pulse(b + 1, 4'b1000);
        pulse(b + 6, 4'b0100);
        drain(b + 14, "simul_drain");

        // Same-direction edge with cancel: cancel dropped, count restarts
        n = cyc + 2;
        b = n + 3;
        push(b, 2'd1, 2'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++)
            push(b + 4 * i - 1, 2'd1, 2'((i - 1) % 4), 1'b0, 1'b1);
        push(b + 64, 2'd0, 2'd0, 1'b0, 1'b0);
        pulse(n, 4'b0001);
        pulse(b + 14, 4'b1001);
        drain(b + 70, "cancel_prio_drain");

        // Pending cancel ends LEFT at the next boundary
        n = cyc + 2;
        b = n + 3;
        push(b, 2'd1, 2'd0, 1'b0, 1'b0);
        push(b + 3, 2'd1, 2'd0, 1'b0, 1'b1);
        push(b + 5, 2'd1, 2'd1, 1'b1, 1'b0);
        push(b + 7, 2'd1, 2'd1, 1'b1, 1'b1);
        push(b + 11, 2'd1, 2'd2, 1'b1, 1'b1);
        push(b + 15, 2'd1, 2'd3, 1'b1, 1'b1);
        push(b + 16, 2'd0, 2'd0, 1'b0, 1'b0);
        pulse(n, 4'b0001);
        pulse(b + 2, 4'b1000);
        drain(b + 22, "pend_cancel_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
